// File: rtl/datapath_sequencer.sv
// Multi-cycle controller for the 4-register, 8-bit datapath. It runs one register-transfer
// instruction at a time (LDI/MOV/XOR/AND/SHL) behind a start/busy/done handshake.
module datapath_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] rd,
  input  logic [1:0] rs,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] sr,
  output logic [1:0] Rn,
  output logic       w,
  output logic [1:0] aluop,
  output logic       lt,
  output logic [2:0] tsel,
  output logic [2:0] bsel
);

  typedef enum logic [1:0] {IDLE, LOADT, EXEC, FIN} state_t;

  localparam logic [2:0] OP_LDI = 3'b000;
  localparam logic [2:0] OP_MOV = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;

  localparam logic [1:0] SR_IN  = 2'b00;
  localparam logic [1:0] SR_ALU = 2'b01;
  localparam logic [1:0] SR_TMP = 2'b10;

  localparam logic [2:0] TSEL_R0  = 3'b010;
  localparam logic [2:0] TSEL_BIN = 3'b100;

  state_t     state, state_next;
  logic [2:0] op_q;
  logic [1:0] rd_q, rs_q;
  logic       err_q;
  logic       accept, reject;

  function automatic logic [2:0] b_map(input logic [1:0] r);
    case (r)
      2'b01:   b_map = 3'b001;
      2'b10:   b_map = 3'b010;
      2'b11:   b_map = 3'b100;
      default: b_map = 3'b000;
    endcase
  endfunction

  assign accept = (state == IDLE) && start;
  // Every opcode except LDI reads Rs, and R0 cannot be selected as the B source.
  assign reject = (opcode > OP_SHL) || ((opcode != OP_LDI) && (rs == 2'b00));

  // NOTE: sequential state uses non-blocking assignments so that all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= OP_LDI;
      rd_q  <= 2'b00;
      rs_q  <= 2'b00;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q  <= opcode;
        rd_q  <= rd;
        rs_q  <= rs;
        err_q <= reject;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (reject)                state_next = FIN;
          else if (opcode == OP_LDI) state_next = EXEC;
          else                       state_next = LOADT;
        end
      end
      LOADT:   state_next = EXEC;
      EXEC:    state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    sr    = SR_IN;
    Rn    = 2'b00;
    w     = 1'b0;
    aluop = 2'b00;
    lt    = 1'b0;
    tsel  = 3'b000;
    bsel  = 3'b000;
    case (state)
      LOADT: begin
        busy = 1'b1;
        lt   = 1'b1;
        if ((op_q == OP_MOV) || (op_q == OP_SHL)) begin
          tsel = TSEL_BIN;
          bsel = b_map(rs_q);
        end else begin
          tsel = TSEL_R0;
        end
      end
      EXEC: begin
        busy = 1'b1;
        w    = 1'b1;
        Rn   = rd_q;
        case (op_q)
          OP_MOV: sr = SR_TMP;
          OP_XOR: begin
            sr    = SR_ALU;
            aluop = 2'b00;
            bsel  = b_map(rs_q);
          end
          OP_AND: begin
            sr    = SR_ALU;
            aluop = 2'b01;
            bsel  = b_map(rs_q);
          end
          OP_SHL: begin
            sr    = SR_ALU;
            aluop = 2'b10;
          end
          default: sr = SR_IN;
        endcase
      end
      FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Held from the accepting edge until the next accept; only meaningful alongside done.
  assign err = err_q;

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle controller that executes one register-transfer instruction at a time on the 4-register, 8-bit datapath: R0–R3, the tmp register, and the XOR/AND/SHL/PASS ALU.
- Accepts instructions through a start/busy/done handshake.
- Drives every datapath control line (sr, Rn, w, aluop, lt, tsel, bsel).
- Sits between a test sequencer or CPU front-end and the datapath. Datapath input `in` and output `out` (= R0) bypass this block.

Parameters:
- none

Ports:
- clk  in  1  rising-edge clock shared with datapath
- reset  in  1  asynchronous, active-high
- start  in  1  instruction valid; sampled only in IDLE
- opcode  in  3  000 LDI, 001 MOV, 010 XOR, 011 AND, 100 SHL, 101–111 illegal
- rd  in  2  destination register R0–R3
- rs  in  2  source register; only 01/10/11 are legal
- busy  out  1  high while an instruction is in flight
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; instruction rejected
- sr  out  2  datapath write-source select: 00 in, 01 alu, 10 tmp
- Rn  out  2  datapath write register
- w  out  1  datapath register write enable
- aluop  out  2  datapath ALU op
- lt  out  1  tmp load enable
- tsel  out  3  one-hot tmp source: 001 alu, 010 R0, 100 Bin
- bsel  out  3  one-hot B source: 001 R1, 010 R2, 100 R3

Behaviour:
- States: IDLE, LOADT, EXEC, FIN. State register and latched opcode/rd/rs use asynchronous reset.
- Reset (any time, including mid-instruction) forces IDLE. All outputs go to 0 immediately: w=0, lt=0, busy=0, done=0, err=0, sr=00, Rn=00, aluop=00, tsel=000, bsel=000. The in-flight instruction is discarded with no write.
- IDLE: busy=0, w=0, lt=0, all selects 0. On start=1 at a rising edge, latch opcode/rd/rs and go to:
  - EXEC for LDI;
  - LOADT for MOV/XOR/AND/SHL with legal rs;
  - FIN with err set for an illegal opcode, or for rs=00 on MOV/XOR/AND/SHL.
- start is ignored while busy=1; no queueing.
- bsel mapping: rs 01→001, 10→010, 11→100. Outputs are decoded from state and the latched fields, not from live inputs.
- LOADT (busy=1, lt=1, w=0):
  - MOV and SHL: tsel=100, bsel=map(rs); tmp ← Rs.
  - XOR and AND: tsel=010; tmp ← R0.
  - Next state EXEC.
- EXEC (busy=1, w=1, Rn=rd, lt=0):
  - LDI: sr=00 (rd ← in).
  - MOV: sr=10 (rd ← tmp).
  - XOR: sr=01, aluop=00, bsel=map(rs) (rd ← R0^Rs).
  - AND: sr=01, aluop=01, bsel=map(rs) (rd ← R0&Rs).
  - SHL: sr=01, aluop=10 (rd ← Rs<<1, MSB dropped, LSB 0).
  - Next state FIN.
- FIN: busy=1, done=1 for exactly one cycle, err as latched, w=0, lt=0. Next state IDLE. The destination register already holds its new value in this cycle.
- err is cleared on the next accepted start and is only meaningful while done=1.
- Latency from the accepting edge to done high:
  - LDI: 2 cycles;
  - MOV/XOR/AND/SHL: 3 cycles;
  - rejected instruction: 1 cycle.
- Back-to-back: the earliest next accept is the edge ending the first IDLE cycle after FIN.
- Hazard rules:
  - rd=rs is legal; tmp was captured a cycle earlier, so the result is correct.
  - rd=00 on XOR/AND overwrites R0 after its use.
  - w and lt are never both 1 in the same cycle.
  - w is high for exactly one cycle per legal instruction and zero for rejected ones.

Test Plan:
- Reset mid-instruction: assert reset during LOADT of MOV → all outputs 0 asynchronously, no register write, and the next LDI executes normally with done 2 cycles after its accepting edge.
- LDI: `in`=8'hA5, rd=01, start → w=1 with Rn=01, sr=00 for one cycle; done (err=0) 2 cycles after the accepting edge; R1=A5.
- Chain: LDI R0=F0, LDI R2=3C, XOR rd=11 rs=10 → lt with tsel=010, then w with aluop=00, bsel=010; R3=CC; done 3 cycles after the XOR accept.
- SHL and AND: R1=81, SHL rd=01 rs=01 → R1=02. Then R0=0F, AND rd=00 rs=01 → R0=02.
- MOV and start ignored: R3=5A, MOV rd=10 rs=11 → R2=5A. A start pulse with opcode=000 during busy is ignored: no extra w, done count stays 1.
- Rejection: opcode=110, and separately MOV with rs=00 → done and err both high 1 cycle after accept; w and lt never asserted; register contents unchanged.
